param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Single-clock, parametrised FIFO. It generalises the team's dual-clock FIFO into a configurable-width, configurable-depth buffer. It adds programmable almost-full/almost-empty thresholds, an occupancy count, a first-word-fall-through (FWFT) mode, synchronous flush and sticky overflow/underflow flags. It sits between producer and consumer logic inside one clock domain.

## Interface
- DATA_W, 8: word width in bits, ≥1
- DEPTH, 16: number of entries; power of two, ≥2; ADDR_W = $clog2(DEPTH)
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush
- wr_req  in  1  write request
- data_in  in  DATA_W  write data
- rd_req  in  1  read request (FWFT: pop/acknowledge)
- data_out  out  DATA_W  read data
- rd_valid  out  1  data_out holds a valid word
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_THRESH
- almost_full  out  1  count ≥ AF_THRESH
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty

## Operation
- Reset values: data_out 0, rd_valid 0, empty 1, full 0, almost_empty 1, almost_full 0, count 0, overflow 0, underflow 0, both pointers 0.
- Pointers are ADDR_W+1 bits and wrap modulo 2·DEPTH. The MSB distinguishes full from empty.
- A write is accepted iff wr_req && !full, judged on the current cycle's full. A request while full is dropped and sets overflow.
- A read is accepted iff rd_req && !empty. A request while empty is dropped and sets underflow.
- Simultaneous write and read accepted in one cycle: count unchanged, both pointers advance.
- A read at full frees space only from the next cycle. The same-cycle write is still rejected.
- A write at empty is not readable in the same cycle.
- clr has priority over wr_req and rd_req. It zeroes the pointers and count, clears rd_valid, overflow and underflow, and forces reset flag values. Memory contents are not cleared.
- FWFT=0: an accepted read registers mem[rd_ptr] into data_out and sets rd_valid for exactly one cycle. data_out holds its value otherwise.
- FWFT=1: data_out = mem[rd_ptr] whenever !empty; rd_valid = !empty. rd_req pops the head word.
- Flags and count are derived from the registered pointers and count. They are glitch-free and never combinational from request inputs.

## Timing
- Write accepted at edge N: count, empty, almost_* and full update after edge N.
- FWFT=1 write into empty FIFO: rd_valid=1 and data valid after the same edge N (1-cycle latency).
- FWFT=0 read accepted at edge N: data_out and rd_valid=1 after edge N; rd_valid drops after N+1 unless another read is accepted.
- Sticky flags set after the offending edge and hold until reset or clr.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronous). Release is synchronised externally.

## Structure
- Package fifo_pkg: clog2-based width helper. Also elaboration-time checks: DEPTH power of two, 0 ≤ AE_THRESH < AF_THRESH ≤ DEPTH.
- Sub-module fifo_ram: DEPTH×DATA_W register array, one synchronous write port, one asynchronous read port. The top holds pointers, count, flags and read register.

## Test plan
- Reset, then idle: empty=1, almost_empty=1, count=0, full=0, rd_valid=0.
- DATA_W=8, DEPTH=4, FWFT=0: write 0xA1,0xA2,0xA3,0xA4 → full=1, count=4. Fifth write 0xFF → dropped, overflow=1. Four reads → 0xA1..0xA4 in order, one cycle after each accepted read.
- Fill to 4, hold rd_req and wr_req together: first cycle only the read is accepted (count 3). Afterwards simultaneous ops keep count=3 across 8 cycles with correct order through pointer wrap.
- FWFT=1: write 0x5C into empty FIFO → next cycle data_out=0x5C, rd_valid=1 without rd_req. A pop gives empty=1 next cycle.
- AE_THRESH=1, AF_THRESH=3, DEPTH=4: counts 0→4 give almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1.
- With count=3 and overflow set, pulse clr with wr_req=1 → count=0, empty=1, overflow=0, write ignored. Then assert rst_n=0 mid-burst → outputs at reset values within the same cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers and parameter checks for param_sync_fifo
package fifo_pkg;

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int ae, input int af, input int depth);
        return (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W register array, sync write, async read
//
// Ports:
//   clk_i    rising-edge clock for the write port
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  combinational read data at raddr_i
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Storage is deliberately not reset; occupancy lives in the pointers.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock parametrised FIFO with flags and FWFT mode
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush (beats wr_req/rd_req)
//   wr_req        write request, accepted when not full
//   data_in       write data
//   rd_req        read request (FWFT: pop of the head word)
//   data_out      read data
//   rd_valid      data_out holds a valid word
//   empty, full   occupancy is 0 / DEPTH
//   almost_empty  count <= AE_THRESH
//   almost_full   count >= AF_THRESH
//   count         occupancy 0..DEPTH
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_req,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_req,
    output logic [DATA_W-1:0]        data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
    localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
        $error("param_sync_fifo: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("param_sync_fifo: DATA_W must be >= 1");
    end

    // Pointers carry one extra wrap bit so they run modulo 2*DEPTH.
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               empty_w, full_w;
    logic               wr_acc, rd_acc;
    logic [DATA_W-1:0]  ram_rdata;

    // Flags come only from registered count, never from the request inputs.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);

    // Acceptance is judged on this cycle's flags: a read at full does not
    // make room for a same-cycle write, nor is a write at empty readable.
    assign wr_acc = wr_req && !full_w;
    assign rd_acc = rd_req && !empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (wr_req && full_w)  overflow_d  = 1'b1;
            if (rd_req && empty_w) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc && !clr),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; forced to zero while empty so
        // stale memory never shows up on data_out.
        assign data_out = empty_w ? '0 : ram_rdata;
        assign rd_valid = !empty_w;
    end else begin : g_reg
        logic [DATA_W-1:0] data_out_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_out_q <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc && !clr;
                if (rd_acc && !clr) begin
                    data_out_q <= ram_rdata;
                end
            end
        end

        assign data_out = data_out_q;
        assign rd_valid = rd_valid_q;
    end

    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] a_dout, b_dout;
    logic       a_valid, b_valid, a_empty, b_empty, a_full, b_full;
    logic       a_ae, b_ae, a_af, b_af, a_ovf, b_ovf, a_unf, b_unf;
    logic [2:0] a_count, b_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_req(wr_req), .data_in(data_in),
        .rd_req(rd_req), .data_out(a_dout), .rd_valid(a_valid), .empty(a_empty),
        .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    param_sync_fifo #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_req(wr_req), .data_in(data_in),
        .rd_req(rd_req), .data_out(b_dout), .rd_valid(b_valid), .empty(b_empty),
        .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    // Behavioural model: a queue of stored words plus the observable registers.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit         m_valid, m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_dout  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (clr) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (mq.size() == 4);
            was_empty = (mq.size() == 0);
            if (wr_req && was_full)  m_ovf = 1'b1;
            if (rd_req && was_empty) m_unf = 1'b1;
            m_valid = rd_req && !was_empty;
            if (rd_req && !was_empty) m_dout = mq.pop_front();
            if (wr_req && !was_full)  mq.push_back(data_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        int n;
        if (chk_on && rst_n) begin
            n = mq.size();
            chk("count_std",  32'(a_count), n);
            chk("count_fwft", 32'(b_count), n);
            chk("empty",      {a_empty, b_empty}, {2{n == 0}});
            chk("full",       {a_full, b_full},   {2{n == 4}});
            chk("almost_e",   {a_ae, b_ae},       {2{n <= 1}});
            chk("almost_f",   {a_af, b_af},       {2{n >= 3}});
            chk("overflow",   {a_ovf, b_ovf},     {2{m_ovf}});
            chk("underflow",  {a_unf, b_unf},     {2{m_unf}});
            chk("dout_std",   32'(a_dout),  32'(m_dout));
            chk("valid_std",  32'(a_valid), 32'(m_valid));
            chk("valid_fwft", 32'(b_valid), 32'(n != 0));
            chk("dout_fwft",  32'(b_dout),  (n != 0) ? 32'(mq[0]) : 32'h0);
        end
    end

    // Apply one cycle of inputs, then return just after the following negedge.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        wr_req  = w;
        data_in = d;
        rd_req  = r;
        clr     = c;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ae_exp;
        logic [7:0] af_exp;
        int wp;
        ae_exp = 8'b0000_0011;  // bit k = expected almost_empty at count k
        af_exp = 8'b0001_1000;  // bit k = expected almost_full at count k

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_on = 1'b1;
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_ae",    32'(a_ae),    1);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_full",  32'(a_full),  0);
        chk("rst_valid", {a_valid, b_valid}, 0);
        chk("rst_dout",  {a_dout, b_dout}, 0);

        // Fill to full, checking threshold flags at each count.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
            chk("thr_ae", 32'(a_ae), 32'(ae_exp[k]));
            chk("thr_af", 32'(a_af), 32'(af_exp[k]));
        end
        chk("fill_full",  32'(a_full),  1);
        chk("fill_count", 32'(a_count), 4);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set",   32'(a_ovf),   1);
        chk("ovf_count", 32'(a_count), 4);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("rd_data",  32'(a_dout),  32'(8'hA0 + 8'(k)));
            chk("rd_valid", 32'(a_valid), 1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rd_valid_drop", 32'(a_valid), 0);
        chk("rd_hold",       32'(a_dout),  32'hA4);

        // Full FIFO with simultaneous requests: only the read goes in first.
        for (int k = 0; k < 4; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0);
        step(1'b1, 8'hC0, 1'b1, 1'b0);
        chk("sim_first_cnt", 32'(a_count), 3);
        chk("sim_first_dat", 32'(a_dout),  32'hB0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'hC0 + 8'(k), 1'b1, 1'b0);
            chk("sim_cnt", 32'(a_count), 3);
        end
        chk("sim_wrap_dat", 32'(a_dout), 32'hC5);

        // Drain, then read while empty.
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(a_unf), 1);

        // FWFT fall-through and pop.
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        chk("fwft_data",  32'(b_dout),  32'h5C);
        chk("fwft_valid", 32'(b_valid), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_empty", 32'(b_empty), 1);
        chk("fwft_novld", 32'(b_valid), 0);

        // Flush beats a concurrent write and clears sticky flags.
        for (int k = 0; k < 3; k++) step(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0);
        chk("pre_clr_ovf", 32'(a_ovf), 1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("clr_count", 32'(a_count), 0);
        chk("clr_empty", 32'(a_empty), 1);
        chk("clr_ovf",   32'(a_ovf),   0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_nowr",  32'(a_count), 0);

        // Randomised traffic with alternating fill/drain bias and rare flushes.
        for (int k = 0; k < 2000; k++) begin
            wp = ((k / 100) % 2 == 0) ? 75 : 25;
            step(($urandom % 100) < wp, 8'($urandom), ($urandom % 100) < (100 - wp),
                 ($urandom % 97) == 0);
        end

        // Asynchronous reset in the middle of a burst.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", {a_count, b_count}, 0);
        chk("arst_empty", {a_empty, b_empty}, 2'b11);
        chk("arst_ae",    {a_ae, b_ae},       2'b11);
        chk("arst_flags", {a_full, b_full, a_af, b_af, a_ovf, b_ovf, a_unf, b_unf}, 0);
        chk("arst_valid", {a_valid, b_valid}, 0);
        chk("arst_dout",  {a_dout, b_dout},   0);
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
